io64_uart_tx: RTL and testbench
===============================

# io64_uart_tx

Output-port consumer for the 15-bit CPU: watches the CPU's 16-bit `IO64_OUT` port, captures every new value into a small FIFO, and serialises each captured word as two 8N1 UART bytes (low byte first) on `TXD`. Sits directly downstream of `cpu15` at the top level, turning port writes into a host-visible serial trace. Captures are decoupled from transmission, so bursts of CPU writes are absorbed up to FIFO depth.

## Interface
- `CLK_DIV`, 16: clock cycles per UART bit; legal range 2..65535.
- `FIFO_DEPTH`, 4: capture FIFO entries; power of two, 2..16.

- `CLK`  in  1  system clock; all logic on rising edge.
- `RESET`  in  1  synchronous, active-high reset.
- `IO64_OUT`  in  16  CPU output port value, sampled every cycle.
- `TXD`  out  1  UART serial output; idle high.
- `BUSY`  out  1  high while the FIFO is non-empty or a frame is in progress.
- `OVERFLOW`  out  1  sticky; set when a captured value is dropped because the FIFO is full.

## Operation
- Change detect: register `prev` (reset 0x0000). At each edge, if `IO64_OUT != prev`: `prev <= IO64_OUT` and push `IO64_OUT` into the FIFO. Equal values are never pushed.
- FIFO full on a push: value dropped, `prev` still updated (no retry), `OVERFLOW <= 1`. Cleared only by `RESET`.
- Push and pop in the same cycle on a full FIFO: pop frees the slot and the push is accepted; no overflow.
- TX FSM states: IDLE, START, DATA, PARITY (macro only), STOP; byte select bit `hi` (0 = low byte).
  - IDLE: `TXD=1`. If FIFO non-empty: pop word into a 16-bit holding register, `hi<=0`, go START.
  - START: `TXD=0` for `CLK_DIV` cycles -> DATA.
  - DATA: 8 bits, LSB first, `CLK_DIV` cycles each -> PARITY or STOP.
  - STOP: `TXD=1` for `CLK_DIV` cycles. If `hi==0`: `hi<=1`, go START (high byte, no gap). Else go IDLE.
- Bit timer: counter 0..`CLK_DIV`-1, reloaded on every bit boundary; bit index counter 0..7.
- `BUSY = (state != IDLE) | fifo_not_empty`, registered-state derived, combinational output.
- `RESET` at any time, including mid-frame: at that edge FSM->IDLE, `TXD=1`, FIFO emptied, `prev=0`, counters 0, `OVERFLOW=0`. A partial frame is abandoned, not completed.

## Timing
- Reset values: `TXD=1`, `BUSY=0`, `OVERFLOW=0`.
- New value present before edge k -> pushed at edge k -> popped at edge k+1, `TXD` falls at edge k+1.
- Byte frame: 10×`CLK_DIV` cycles (11× with parity). Word: 20×`CLK_DIV` (22×) cycles, no gap between low and high byte.
- After a word's high-byte stop bit: exactly one IDLE cycle (`TXD=1`) before the next word's start bit if the FIFO is non-empty.
- `BUSY` falls on the edge entering IDLE with the FIFO empty.

## Configuration
- `IO64_UART_TX_PARITY_EN` defined: PARITY state inserted after DATA, sending one even-parity bit (XOR of the 8 data bits) for `CLK_DIV` cycles; 8E1 framing, 11 bits per byte.
- Not defined: no PARITY state, 8N1 framing, 10 bits per byte.

## Test plan
All with `CLK_DIV=4`, `FIFO_DEPTH=4`, unless stated.
- Hold `RESET=1` 3 cycles, `IO64_OUT=0` -> `TXD=1`, `BUSY=0`, `OVERFLOW=0`; no frame while `IO64_OUT` stays 0.
- `IO64_OUT` 0->0x1234 before edge 10 -> `TXD=0` from edge 11 for 4 cycles, then bits 0,0,1,0,1,1,0,0 (0x34), stop, immediately start + 0x12; 80 cycles total, then `BUSY=0`.
- Keep `IO64_OUT=0x1234` 200 more cycles -> `TXD` stays 1, `BUSY=0`.
- Drive 6 distinct values on 6 consecutive edges -> values 1-5 transmitted in order, value 6 dropped, `OVERFLOW=1` from the sixth edge and held.
- Assert `RESET` for 1 cycle during the high byte of a word with 2 words queued -> `TXD=1` at next edge, `BUSY=0`, `OVERFLOW=0`, no further frames.
- With `IO64_UART_TX_PARITY_EN`, `IO64_OUT=0x0107` -> low byte 0x07 with parity bit 1, high byte 0x01 with parity bit 1, 88 cycles total.

Source files
------------

// File: rtl/io64_uart_tx.sv
// Purpose: capture each new IO64_OUT value into a FIFO and send it as two UART bytes on TXD, low byte first.
// Latency: a value that changes before edge k is pushed at edge k, and its start bit drives TXD from edge k+1.
// Backpressure: none upstream. A change that arrives while the FIFO is full is dropped and sets the sticky OVERFLOW flag.
// Build option: define IO64_UART_TX_PARITY_EN to add an even-parity bit to each byte (8E1 instead of 8N1).
module io64_uart_tx #(
   parameter int CLK_DIV    = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic [15:0] IO64_OUT,
   output logic        TXD,
   output logic        BUSY,
   output logic        OVERFLOW
);

   localparam int          AW       = $clog2(FIFO_DEPTH);
   localparam int          CNT_W    = AW + 1;
   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_STOP
`ifdef IO64_UART_TX_PARITY_EN
      , ST_PARITY
`endif
   } state_t;

   state_t           state;
   logic [15:0]      prev;
   logic [15:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CNT_W-1:0] count;
   logic [15:0]      hold;
   logic             hi;
   logic [15:0]      timer;
   logic [2:0]       bit_idx;
   logic [7:0]       cur_byte;
   logic             fifo_nonempty;
   logic             fifo_full;
   logic             push_req;
   logic             push_ok;
   logic             pop;
   logic             bit_end;

   assign fifo_nonempty = (count != '0);
   assign fifo_full     = (count == CNT_W'(FIFO_DEPTH));
   assign push_req      = (IO64_OUT != prev);
   // The FSM only pops while it is IDLE. A same-cycle pop frees a slot, so that push is still accepted.
   assign pop           = (state == ST_IDLE) && fifo_nonempty;
   assign push_ok       = push_req && (!fifo_full || pop);
   assign cur_byte      = hi ? hold[15:8] : hold[7:0];
   assign bit_end       = (timer == DIV_LAST);
   assign BUSY          = (state != ST_IDLE) || fifo_nonempty;

   // Change detect, FIFO pointers and sticky overflow. prev follows the input even when a push is dropped.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         prev     <= 16'h0000;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         OVERFLOW <= 1'b0;
      end else begin
         if (push_req)
            prev <= IO64_OUT;
         if (push_req && !push_ok)
            OVERFLOW <= 1'b1;
         if (push_ok)
            wr_ptr <= wr_ptr + AW'(1);
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count + CNT_W'(push_ok) - CNT_W'(pop);
      end
   end

   // FIFO storage. Reset does not clear it, because the pointers already mark every entry as invalid.
   always_ff @(posedge CLK) begin
      if (!RESET && push_ok)
         mem[wr_ptr] <= IO64_OUT;
   end

   // Transmit FSM. TXD is registered, so it changes on the same edge as the state it belongs to.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= ST_IDLE;
         TXD     <= 1'b1;
         hold    <= 16'h0000;
         hi      <= 1'b0;
         timer   <= 16'h0000;
         bit_idx <= 3'd0;
      end else begin
         case (state)
            ST_IDLE: begin
               TXD <= 1'b1;
               if (pop) begin
                  hold    <= mem[rd_ptr];
                  hi      <= 1'b0;
                  timer   <= 16'h0000;
                  bit_idx <= 3'd0;
                  TXD     <= 1'b0;
                  state   <= ST_START;
               end
            end
            ST_START: begin
               if (bit_end) begin
                  timer   <= 16'h0000;
                  bit_idx <= 3'd0;
                  TXD     <= cur_byte[0];
                  state   <= ST_DATA;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            ST_DATA: begin
               if (bit_end) begin
                  timer <= 16'h0000;
                  if (bit_idx == 3'd7) begin
`ifdef IO64_UART_TX_PARITY_EN
                     TXD   <= ^cur_byte;
                     state <= ST_PARITY;
`else
                     TXD   <= 1'b1;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     TXD     <= cur_byte[bit_idx + 3'd1];
                  end
               end else begin
                  timer <= timer + 16'd1;
               end
            end
`ifdef IO64_UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_end) begin
                  timer <= 16'h0000;
                  TXD   <= 1'b1;
                  state <= ST_STOP;
               end else begin
                  timer <= timer + 16'd1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_end) begin
                  timer <= 16'h0000;
                  if (!hi) begin
                     // The high byte's start bit follows the low byte's stop bit with no gap.
                     hi    <= 1'b1;
                     TXD   <= 1'b0;
                     state <= ST_START;
                  end else begin
                     TXD   <= 1'b1;
                     state <= ST_IDLE;
                  end
               end else begin
                  timer <= timer + 16'd1;
               end
            end
            default: begin
               TXD   <= 1'b1;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_io64_uart_tx.sv
// Testbench for io64_uart_tx with CLK_DIV=4 and FIFO_DEPTH=4. A serial monitor decodes words from TXD and compares them with a scoreboard queue.
// Sampling: TXD is sampled mid-bit on negedges. Inputs are driven 1 time unit after posedge.
// Parity: define IO64_UART_TX_PARITY_EN for this bench as well, so that it expects 8E1 frames.
module tb_io64_uart_tx;

   localparam int DIV = 4;
`ifdef IO64_UART_TX_PARITY_EN
   localparam int          NB = 11;
   localparam logic [15:0] W2 = 16'h0107;
`else
   localparam int          NB = 10;
   localparam logic [15:0] W2 = 16'h1234;
`endif
   localparam int WORD_CYC = 2 * NB * DIV;

   logic        CLK;
   logic        RESET;
   logic [15:0] IO64_OUT;
   logic        TXD;
   logic        BUSY;
   logic        OVERFLOW;

   int          n_chk;
   int          n_fail;
   logic [15:0] exp_q[$];
   int          starts[$];
   int          mon_words;

   io64_uart_tx #(.CLK_DIV(DIV), .FIFO_DEPTH(4)) dut (
      .CLK      (CLK),
      .RESET    (RESET),
      .IO64_OUT (IO64_OUT),
      .TXD      (TXD),
      .BUSY     (BUSY),
      .OVERFLOW (OVERFLOW)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected TXD level in frame-bit slot i of word w (each slot lasts DIV cycles).
   function automatic logic frame_bit(input logic [15:0] w, input int i);
      logic [7:0] b;
      int         j;
      b = (i < NB) ? w[7:0] : w[15:8];
      j = i % NB;
      if (j == 0) return 1'b0;
      if (j <= 8) return b[j-1];
      if (j == 9 && NB == 11) return ^b;
      return 1'b1;
   endfunction

   task automatic drive_word(input logic [15:0] v, input bit expect_tx);
      IO64_OUT = v;
      if (expect_tx) exp_q.push_back(v);
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget && (exp_q.size() != 0 || BUSY); i++) @(negedge CLK);
      check("drain_queue", 32'(exp_q.size()), 32'd0);
      check("drain_busy", 32'(BUSY), 32'd0);
   endtask

   // Serial monitor: decodes frames mid-bit and pops the scoreboard on every complete word.
   initial begin
      bit          active;
      bit          have_lo;
      int          cnt;
      int          cyc;
      int          j;
      int          st;
      int          lo_start;
      logic [7:0]  mbyte;
      logic [7:0]  lo;
      logic [15:0] word;
      logic [15:0] e;
      active = 0; have_lo = 0; cnt = 0; cyc = 0; st = 0; lo_start = 0;
      mbyte = '0; lo = '0; mon_words = 0;
      forever begin
         @(negedge CLK);
         cyc++;
         if (RESET) begin
            active  = 0;
            have_lo = 0;
         end else if (!active) begin
            if (TXD == 1'b0) begin
               active = 1;
               cnt    = 0;
               st     = cyc;
            end
         end else begin
            cnt++;
            if (cnt % DIV == DIV / 2) begin
               j = cnt / DIV;
               if (j == 0) begin
                  check("start_bit", 32'(TXD), 32'd0);
               end else if (j <= 8) begin
                  mbyte[j-1] = TXD;
               end else if (j == NB - 1) begin
                  check("stop_bit", 32'(TXD), 32'd1);
                  active = 0;
                  if (!have_lo) begin
                     lo       = mbyte;
                     have_lo  = 1;
                     lo_start = st;
                  end else begin
                     check("hi_gap", 32'(st - lo_start), 32'(NB * DIV));
                     have_lo = 0;
                     word    = {mbyte, lo};
                     check("sb_has_exp", 32'(exp_q.size() != 0), 32'd1);
                     if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("sb_word", 32'(word), 32'(e));
                     end
                     mon_words++;
                     starts.push_back(lo_start);
                  end
               end else begin
                  check("parity_bit", 32'(TXD), 32'(^mbyte));
               end
            end
         end
      end
   end

   initial begin
      logic [15:0] vals [6];
      int          w_before;
      n_chk = 0;
      n_fail = 0;
      RESET = 1'b1;
      IO64_OUT = 16'h0000;
      vals[0] = 16'h0001; vals[1] = 16'h00FF; vals[2] = 16'hA55A;
      vals[3] = 16'h8001; vals[4] = 16'h7FFE; vals[5] = 16'hDEAD;

      // Reset held for 3 edges; IO64_OUT held at 0 must not start a frame.
      repeat (3) @(posedge CLK);
      #1 RESET = 1'b0;
      check("rst_txd", 32'(TXD), 32'd1);
      check("rst_busy", 32'(BUSY), 32'd0);
      check("rst_ovf", 32'(OVERFLOW), 32'd0);
      for (int i = 0; i < 20; i++) begin
         @(negedge CLK);
         check("zero_quiet", 32'({TXD, BUSY}), 32'b10);
      end

      // Single word: exact cycle-by-cycle waveform.
      @(posedge CLK);
      #1 drive_word(W2, 1'b1);
      @(posedge CLK);
      @(negedge CLK);
      check("push_txd_high", 32'(TXD), 32'd1);
      check("push_busy", 32'(BUSY), 32'd1);
      for (int c = 0; c < WORD_CYC; c++) begin
         @(negedge CLK);
         check("wave", 32'(TXD), 32'(frame_bit(W2, c / DIV)));
      end
      @(negedge CLK);
      check("word_end_busy", 32'(BUSY), 32'd0);
      check("word_end_txd", 32'(TXD), 32'd1);
      check("sb_single", 32'(exp_q.size()), 32'd0);

      // Holding an unchanged value produces no further frames.
      for (int i = 0; i < 200; i++) begin
         @(negedge CLK);
         check("hold_quiet", 32'({TXD, BUSY}), 32'b10);
      end

      // Six distinct values on consecutive edges: five sent, the sixth dropped.
      starts.delete();
      for (int i = 0; i < 6; i++) begin
         @(posedge CLK);
         #1;
         if (i == 5) check("ovf_before", 32'(OVERFLOW), 32'd0);
         drive_word(vals[i], i < 5);
      end
      @(posedge CLK);
      #1 check("ovf_set", 32'(OVERFLOW), 32'd1);
      wait_drain(5 * (WORD_CYC + 1) + 40);
      check("ovf_held", 32'(OVERFLOW), 32'd1);
      check("burst_words", 32'(starts.size()), 32'd5);
      for (int i = 1; i < starts.size(); i++)
         check("idle_gap", 32'(starts[i] - starts[i-1]), 32'(WORD_CYC + 1));

      // Reset during the high byte, with two more words queued.
      @(posedge CLK);
      #1 drive_word(16'h1357, 1'b1);
      @(posedge CLK);
      #1 drive_word(16'h2468, 1'b1);
      @(posedge CLK);
      #1 drive_word(16'h9ABC, 1'b1);
      repeat (NB * DIV + 6) @(posedge CLK);
      #1;
      check("mid_busy", 32'(BUSY), 32'd1);
      w_before = mon_words;
      RESET = 1'b1;
      IO64_OUT = 16'h0000;
      exp_q.delete();
      @(posedge CLK);
      #1 RESET = 1'b0;
      check("mrst_txd", 32'(TXD), 32'd1);
      check("mrst_busy", 32'(BUSY), 32'd0);
      check("mrst_ovf", 32'(OVERFLOW), 32'd0);
      for (int i = 0; i < 300; i++) begin
         @(negedge CLK);
         check("post_rst_quiet", 32'({TXD, BUSY, OVERFLOW}), 32'b100);
      end
      check("post_rst_words", 32'(mon_words), 32'(w_before));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
